// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   baud_cnt_max() : sys_clk cycles per bit (integer division, truncating).
//   cnt_width()    : width of the baud counter, never less than 13 bits.
//   tx_state_t     : transmitter FSM encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Also used by the receiver, so both sides agree on the bit period.
    function automatic int baud_cnt_max(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // The 13-bit floor keeps the counter wide enough for 9600 baud at 50 MHz
    // (5208 cycles/bit) even if a caller passes a smaller count.
    function automatic int cnt_width(input int cnt_max);
        int w;
        w = $clog2(cnt_max);
        return (w < 13) ? 13 : w;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt: bit-period counter.
//   sys_clk  in  : system clock
//   sys_rstn in  : asynchronous active-low reset
//   en       in  : count while high, held at 0 while low
//   bit_end  out : high during the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int CNT_MAX = 5208,
    parameter int CNT_W   = 13
) (
    input  logic sys_clk,
    input  logic sys_rstn,
    input  logic en,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the clock edge, independent of block order.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx: UART transmitter. Frame = start, 8 data bits LSB first, optional
// parity bit, 1 or 2 stop bits. Each bit lasts CLK_FREQ/UART_BAUD_RATE cycles.
//   sys_clk   in  : system clock
//   sys_rstn  in  : asynchronous active-low reset
//   pi_data   in  : byte to send, sampled on the accept cycle only
//   pi_flag   in  : request strobe, accepted when tx_ready is high
//   tx        out : serial line, idle high, driven from a flop
//   tx_ready  out : high while idle (a request will be accepted this cycle)
//   flag_done out : one-cycle pulse on the cycle the FSM re-enters IDLE
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int UART_BAUD_RATE = 9600,
    parameter int CLK_FREQ       = 50_000_000,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rstn,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       tx_ready,
    output logic       flag_done
);

    localparam int   BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BAUD_RATE);
    localparam int   CNT_W        = cnt_width(BAUD_CNT_MAX);
    localparam logic ODD          = (PARITY_ODD != 0);
    localparam logic LAST_STOP    = (STOP_BITS == 2);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (BAUD_CNT_MAX < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/UART_BAUD_RATE must be at least 2");
    end

    tx_state_t  state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic       stop_idx, stop_idx_n;
    logic       parity_bit, parity_n;
    logic       tx_n, done_n;
    logic       bit_end;

    uart_baud_cnt #(
        .CNT_MAX (BAUD_CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_baud_cnt (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .en       (state != IDLE),
        .bit_end  (bit_end)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        parity_n   = parity_bit;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (pi_flag) begin
                    shift_n    = pi_data;
                    parity_n   = (^pi_data) ^ ODD;
                    bit_idx_n  = 3'd0;
                    stop_idx_n = 1'b0;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        stop_idx_n = 1'b0;
                        state_n    = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == LAST_STOP) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is decoded from the next state so the line flop changes on the
        // same edge as the state register (one-cycle latency, glitch-free).
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            flag_done  <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_idx    <= bit_idx_n;
            stop_idx   <= stop_idx_n;
            parity_bit <= parity_n;
            tx         <= tx_n;
            flag_done  <= done_n;
        end
    end

    assign tx_ready = (state == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx: three transmitters with different framing run from one clock.
//   dut 0 : 8N1, 10 cycles/bit
//   dut 1 : 8E2, 12 cycles/bit (1_000_000/83_333 truncates to 12)
//   dut 2 : 8O1, 10 cycles/bit
// The expected frame is built from the byte as a list of line levels; the
// line is then compared against it every cycle and decoded mid-bit.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk;
    logic       rstn;
    logic [2:0] flag;
    logic [7:0] pdata [3];
    wire  [2:0] tx;
    wire  [2:0] rdy;
    wire  [2:0] done;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx #(.UART_BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
              .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .sys_clk(clk), .sys_rstn(rstn), .pi_data(pdata[0]), .pi_flag(flag[0]),
        .tx(tx[0]), .tx_ready(rdy[0]), .flag_done(done[0]));

    uart_tx #(.UART_BAUD_RATE(83_333), .CLK_FREQ(1_000_000),
              .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .sys_clk(clk), .sys_rstn(rstn), .pi_data(pdata[1]), .pi_flag(flag[1]),
        .tx(tx[1]), .tx_ready(rdy[1]), .flag_done(done[1]));

    uart_tx #(.UART_BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
              .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .sys_clk(clk), .sys_rstn(rstn), .pi_data(pdata[2]), .pi_flag(flag[2]),
        .tx(tx[2]), .tx_ready(rdy[2]), .flag_done(done[2]));

    function automatic int nper(input int k);
        return (k == 1) ? 12 : 10;
    endfunction
    function automatic int pen(input int k);
        return (k == 0) ? 0 : 1;
    endfunction
    function automatic int podd(input int k);
        return (k == 2) ? 1 : 0;
    endfunction
    function automatic int nstop(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sends byte d on dut k and checks the whole frame.
    //   armed   : request already driven (chained from the previous frame)
    //   chain   : raise the next request on the flag_done cycle with next_d
    //   poke_at : frame cycle at which a stray request (0x00) is pulsed, -1 none
    task automatic run_frame(input int k, input logic [7:0] d, input bit armed,
                             input bit chain, input logic [7:0] next_d, input int poke_at);
        int         n, nb, len, ones, waited, bi, ready_low, done_hits;
        int         good [12];
        logic       lvl  [12];
        logic [7:0] rx;
        string      id;

        n    = nper(k);
        nb   = 9 + pen(k) + nstop(k);
        len  = nb * n;
        id   = $sformatf("dut%0d 0x%02h", k, d);
        ones = 0;
        rx   = 8'h00;
        lvl[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lvl[1+i] = d[i];
            ones += int'(d[i]);
        end
        if (pen(k) != 0) lvl[9] = ((ones % 2) != podd(k));
        for (int i = 9 + pen(k); i < nb; i++) lvl[i] = 1'b1;
        for (int i = 0; i < 12; i++) good[i] = 0;
        ready_low = 0;
        done_hits = 0;

        if (!armed) begin
            waited = 0;
            @(negedge clk);
            while (rdy[k] !== 1'b1 && waited < 500) begin
                @(negedge clk);
                waited++;
            end
            if (rdy[k] !== 1'b1) check({id, " ready timeout"}, 32'(rdy[k]), 1);
            flag[k]  = 1'b1;
            pdata[k] = d;
        end
        @(posedge clk);
        #1;
        flag[k]  = 1'b0;
        pdata[k] = 8'($urandom);

        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            if (c < len) begin
                bi = c / n;
                if (tx[k] === lvl[bi]) good[bi]++;
                if (rdy[k] === 1'b0) ready_low++;
                if (done[k] !== 1'b0) done_hits++;
                if (bi >= 1 && bi <= 8 && (c % n) == n / 2) rx[bi-1] = tx[k];
                if (c == poke_at) begin
                    flag[k]  = 1'b1;
                    pdata[k] = 8'h00;
                end
                if (c == poke_at + 1) flag[k] = 1'b0;
            end else begin
                check({id, " done at end"}, 32'(done[k]), 1);
                check({id, " ready at end"}, 32'(rdy[k]), 1);
                check({id, " tx idle at end"}, 32'(tx[k]), 1);
                if (chain) begin
                    flag[k]  = 1'b1;
                    pdata[k] = next_d;
                end
            end
        end

        for (int i = 0; i < nb; i++)
            check($sformatf("%s bit%0d cycles at level %0d", id, i, lvl[i]), good[i], n);
        check({id, " ready low cycles"}, ready_low, len);
        check({id, " early done pulses"}, done_hits, 0);
        check({id, " decoded byte"}, rx, d);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] rnd [6];
        bit         chn [6];

        rstn = 1'b0;
        flag = 3'b000;
        for (int k = 0; k < 3; k++) pdata[k] = 8'h00;

        check("pkg baud_cnt_max default", uart_pkg::baud_cnt_max(50_000_000, 9600), 5208);
        check("pkg cnt_width default", uart_pkg::cnt_width(5208), 13);
        check("pkg cnt_width floor", uart_pkg::cnt_width(10), 13);

        #23;
        check("reset tx", 32'(tx), 32'h7);
        check("reset ready", 32'(rdy), 32'h7);
        check("reset done", 32'(done), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1: basic frame, back-to-back, busy request, line patterns
        run_frame(0, 8'h55, 0, 0, 8'h00, -1);
        run_frame(0, 8'hFF, 0, 1, 8'h3C, -1);
        run_frame(0, 8'h3C, 1, 0, 8'h00, -1);
        run_frame(0, 8'h81, 0, 0, 8'h00, 35);
        run_frame(0, 8'h00, 0, 0, 8'h00, -1);
        run_frame(0, 8'hAA, 0, 0, 8'h00, -1);

        // reset during data bit 3 abandons the frame at once
        @(negedge clk);
        flag[0]  = 1'b1;
        pdata[0] = 8'h5A;
        @(posedge clk);
        #1;
        flag[0] = 1'b0;
        repeat (44) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("mid-frame reset tx", 32'(tx[0]), 1);
        check("mid-frame reset ready", 32'(rdy[0]), 1);
        check("mid-frame reset done", 32'(done[0]), 0);
        repeat (3) begin
            @(negedge clk);
            check("reset held done", 32'(done[0]), 0);
        end
        rstn = 1'b1;
        repeat (15) begin
            @(negedge clk);
            check("after reset no done", 32'(done[0]), 0);
        end
        run_frame(0, 8'h12, 0, 0, 8'h00, -1);

        // parity frames
        run_frame(1, 8'h55, 0, 0, 8'h00, -1);
        run_frame(1, 8'h07, 0, 0, 8'h00, -1);
        run_frame(1, 8'hA3, 0, 0, 8'h00, -1);
        run_frame(2, 8'h55, 0, 0, 8'h00, -1);
        run_frame(2, 8'h07, 0, 0, 8'h00, -1);

        // random bytes, randomly chained back-to-back
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) begin
                rnd[i] = 8'($urandom);
                chn[i] = (i < 5) && ($urandom_range(0, 1) == 1);
            end
            for (int i = 0; i < 6; i++)
                run_frame(k, rnd[i], (i > 0) && chn[i-1], chn[i],
                          (i < 5) ? rnd[(i < 5) ? i + 1 : i] : 8'h00, -1);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
